// File: rtl/clk_tick_gen_multi_if.sv
// Control/status bundle for the multi-channel tick generator.
// The master drives enables, divisor loads and modes; the slave returns ticks and divisor readback.
`timescale 1ns/1ps
interface clk_tick_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 29
);
    logic                    en;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       div_load;
    logic [CNT_W-1:0]        div_in;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH-1:0]       tick_out;
    logic [NUM_CH*CNT_W-1:0] div_rd;

    modport master (
        output en, sync_clr, div_load, div_in, mode,
        input  tick_out, div_rd
    );

    modport slave (
        input  en, sync_clr, div_load, div_in, mode,
        output tick_out, div_rd
    );
endinterface

// File: rtl/clk_tick_gen_multi.sv
// Multi-channel clock-enable generator: each channel divides clk100MHz by a runtime-loadable
// divisor and presents either a 1-cycle pulse or a 50% square strobe.
`timescale 1ns/1ps
module clk_tick_ch #(
    parameter int CNT_W       = 29,
    parameter int DIV_DEFAULT = 200_000_000,
    parameter bit TEST_MODE   = 1'b0,
    parameter int TEST_DIV    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sync_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_mode,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_div
);
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_sq;
    logic [CNT_W-1:0] w_n;

    assign w_n = TEST_MODE ? CNT_W'(TEST_DIV) : r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= CNT_W'(DIV_DEFAULT);
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_sq    <= 1'b0;
        end else if (i_sync_clr) begin
            // Clear wins over counting, but a coincident load is still captured.
            if (i_load) r_div <= i_div;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_sq    <= 1'b0;
        end else if (i_load) begin
            r_div   <= i_div;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_sq    <= 1'b0;
        end else if (!i_en) begin
            r_pulse <= 1'b0;
        end else if (w_n == '0) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_sq    <= 1'b0;
        end else if (r_cnt == w_n - CNT_W'(1)) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_sq    <= ~r_sq;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_pulse <= 1'b0;
        end
    end

    assign o_tick = i_mode ? r_sq : r_pulse;
    assign o_div  = r_div;
endmodule

module clk_tick_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 29,
    parameter int DIV_DEFAULT = 200_000_000,
    parameter bit TEST_MODE   = 1'b0,
    parameter int TEST_DIV    = 8
) (
    input  logic                  clk100MHz,
    input  logic                  rst_n,
    clk_tick_gen_multi_if.slave   bus
);
    logic [NUM_CH-1:0]            w_tick;
    logic [NUM_CH-1:0][CNT_W-1:0] w_div;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_tick_ch #(
            .CNT_W      (CNT_W),
            .DIV_DEFAULT(DIV_DEFAULT),
            .TEST_MODE  (TEST_MODE),
            .TEST_DIV   (TEST_DIV)
        ) u_ch (
            .clk       (clk100MHz),
            .rst_n     (rst_n),
            .i_en      (bus.en),
            .i_sync_clr(bus.sync_clr),
            .i_load    (bus.div_load[i]),
            .i_div     (bus.div_in),
            .i_mode    (bus.mode[i]),
            .o_tick    (w_tick[i]),
            .o_div     (w_div[i])
        );
    end

    // Packed [ch][bit] flattens so channel i lands at [i*CNT_W +: CNT_W].
    assign bus.tick_out = w_tick;
    assign bus.div_rd   = w_div;
endmodule
